// File: rtl/hilo_pkg.sv
// Shared constants, control bundle and FSM encoding for the EX-stage HI/LO unit.
package hilo_pkg;

    localparam logic [3:0] ALU_MULT    = 4'b0110;
    localparam logic [3:0] ALU_MULTU   = 4'b0111;

    localparam logic [1:0] REGSEL_NONE = 2'b00;
    localparam logic [1:0] REGSEL_HI   = 2'b01;
    localparam logic [1:0] REGSEL_LO   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } hilo_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] alu_op;
        logic       enhilo;
        logic [1:0] regsel;
    } ex_ctrl_t;

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

endpackage

// File: rtl/mult_iter_core.sv
// Iterative shift-add multiplier: magnitudes in, one multiplier bit per step,
// sign applied combinationally to the finished accumulator.
module mult_iter_core
    import hilo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic              step,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [XLEN-1:0]   rt_data,
    output logic              done,
    output logic [2*XLEN-1:0] product
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mplier;
    logic [CW-1:0]     cnt;
    logic              neg;
    logic [XLEN-1:0]   rs_mag;
    logic [XLEN-1:0]   rt_mag;

    // Negating the most negative value wraps back to 2^(XLEN-1), which is the
    // correct magnitude once read as unsigned.
    assign rs_mag = (signed_op && rs_data[XLEN-1]) ? -rs_data : rs_data;
    assign rt_mag = (signed_op && rt_data[XLEN-1]) ? -rt_data : rt_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else if (start) begin
            mcand  <= {{XLEN{1'b0}}, rs_mag};
            mplier <= rt_mag;
            neg    <= signed_op & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    assign done    = step && (cnt == LAST);
    assign product = neg ? -acc : acc;

endmodule

// File: rtl/hilo_mult_unit.sv
// EX-stage HI/LO unit: FSM glue around the iterative multiplier, HI/LO pair,
// dependency stall and MFHI/MFLO read mux.
module hilo_mult_unit
    import hilo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_EX,
    input  logic [3:0]      alu_op,
    input  logic            enhilo_EX,
    input  logic [1:0]      regsel_EX,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            busy,
    output logic            stall_o,
    output logic [XLEN-1:0] hilo_rdata
);

    ex_ctrl_t          ctrl;
    hilo_state_t       state;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              start;
    logic              step;
    logic              done;
    logic              reads_hilo;
    logic [2*XLEN-1:0] product;

    assign ctrl = '{valid: valid_EX, alu_op: alu_op, enhilo: enhilo_EX, regsel: regsel_EX};

    assign start = (state == IDLE) && ctrl.valid && ctrl.enhilo && is_mult_op(ctrl.alu_op);
    assign step  = (state == RUN);

    mult_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (ctrl.alu_op == ALU_MULT),
        .step      (step),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .done      (done),
        .product   (product)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (done)  state <= FIX;
                FIX:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // HI and LO commit together, only on the FIX cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIX) begin
            {hi_q, lo_q} <= product;
        end
    end

    assign busy       = (state != IDLE);
    assign reads_hilo = (ctrl.regsel == REGSEL_HI) || (ctrl.regsel == REGSEL_LO);
    assign stall_o    = busy && ctrl.valid && (ctrl.enhilo || reads_hilo);

    always_comb begin
        hilo_rdata = '0;
        case (ctrl.regsel)
            REGSEL_HI: hilo_rdata = hi_q;
            REGSEL_LO: hilo_rdata = lo_q;
            default:   hilo_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard bench for hilo_mult_unit: reads push expected data, a negedge
// monitor pops and compares whenever an unstalled MFHI/MFLO is in EX.
module tb_hilo_mult_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_EX = 1'b0;
    logic [3:0]  alu_op = '0;
    logic        enhilo_EX = 1'b0;
    logic [1:0]  regsel_EX = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        busy;
    logic        stall_o;
    logic [31:0] hilo_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    hilo_mult_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_EX   (valid_EX),
        .alu_op     (alu_op),
        .enhilo_EX  (enhilo_EX),
        .regsel_EX  (regsel_EX),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .busy       (busy),
        .stall_o    (stall_o),
        .hilo_rdata (hilo_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one pop per read that actually leaves EX.
    always @(negedge clk) begin
        if (rst && valid_EX && !stall_o &&
            (regsel_EX == REGSEL_HI || regsel_EX == REGSEL_LO)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_unexpected: got %h expected no read", hilo_rdata);
            end else begin
                chk("hilo_rdata", hilo_rdata, exp_q.pop_front());
            end
        end
    end

    // Present one instruction, hold it while stalled, retire it on the accepting edge.
    task automatic issue(input logic [3:0] op, input logic en, input logic [1:0] rsel,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_rd,
                         output int stalls, output logic busy_at);
        @(posedge clk); #1;
        valid_EX = 1'b1; alu_op = op; enhilo_EX = en; regsel_EX = rsel;
        rs_data = a; rt_data = b;
        if (rsel == REGSEL_HI || rsel == REGSEL_LO)
            exp_q.push_back(exp_rd);
        stalls = 0;
        busy_at = 1'b0;
        forever begin
            @(negedge clk);
            busy_at = busy;
            if (!stall_o) break;
            stalls++;
            if (stalls > 200) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout: got %0d stalled cycles expected release", stalls);
                break;
            end
        end
        @(posedge clk); #1;
        valid_EX = 1'b0; alu_op = '0; enhilo_EX = 1'b0; regsel_EX = '0;
        rs_data = '0; rt_data = '0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL busy_timeout: got %0d busy cycles expected idle", n);
                break;
            end
        end
    endtask

    initial begin
        int   st;
        int   n;
        logic bz;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        issue(4'h0, 1'b0, REGSEL_HI, 0, 0, 32'h0, st, bz);
        issue(4'h0, 1'b0, REGSEL_LO, 0, 0, 32'h0, st, bz);

        // MULTU max x max: 33 busy cycles
        issue(ALU_MULTU, 1'b1, REGSEL_NONE, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, st, bz);
        chk("multu_accept_stall", st, 0);
        wait_idle(n);
        chk("busy_cycles", n, 33);
        issue(4'h0, 1'b0, REGSEL_HI, 0, 0, 32'hFFFFFFFE, st, bz);
        issue(4'h0, 1'b0, REGSEL_LO, 0, 0, 32'h00000001, st, bz);

        // MULT -3*5 then a MULTU held behind it
        issue(ALU_MULT, 1'b1, REGSEL_NONE, 32'hFFFFFFFD, 32'd5, 0, st, bz);
        issue(ALU_MULTU, 1'b1, REGSEL_NONE, 32'hFFFFFFFD, 32'd5, 0, st, bz);
        chk("mult_behind_mult_stall", st, 32);
        chk("first_result_hi", dut.hi_q, 32'hFFFFFFFF);
        chk("first_result_lo", dut.lo_q, 32'hFFFFFFF1);
        issue(4'h0, 1'b0, REGSEL_HI, 0, 0, 32'h00000004, st, bz);
        chk("mfhi_stall", st, 32);
        issue(4'h0, 1'b0, REGSEL_LO, 0, 0, 32'hFFFFFFF1, st, bz);
        chk("mflo_no_stall", st, 0);

        // most negative squared, with an independent ADD during the run
        issue(ALU_MULT, 1'b1, REGSEL_NONE, 32'h80000000, 32'h80000000, 0, st, bz);
        issue(4'h0, 1'b0, REGSEL_NONE, 32'd1, 32'd2, 0, st, bz);
        chk("add_busy_seen", {31'd0, bz}, 32'd1);
        chk("add_stall", st, 0);
        issue(4'h0, 1'b0, REGSEL_HI, 0, 0, 32'h40000000, st, bz);
        chk("mfhi_after_add_stall", st, 30);
        issue(4'h0, 1'b0, REGSEL_LO, 0, 0, 32'h00000000, st, bz);

        // 7 * -2
        issue(ALU_MULT, 1'b1, REGSEL_NONE, 32'd7, 32'hFFFFFFFE, 0, st, bz);
        issue(4'h0, 1'b0, REGSEL_HI, 0, 0, 32'hFFFFFFFF, st, bz);
        chk("mfhi_stall2", st, 32);
        issue(4'h0, 1'b0, REGSEL_LO, 0, 0, 32'hFFFFFFF2, st, bz);

        // enhilo with a non-multiply op must not start
        issue(4'h0, 1'b1, REGSEL_NONE, 32'd9, 32'd9, 0, st, bz);
        @(negedge clk);
        chk("non_mult_no_start", {31'd0, busy}, 32'd0);
        issue(4'h0, 1'b0, REGSEL_LO, 0, 0, 32'hFFFFFFF2, st, bz);

        // reset during RUN cycle 10
        issue(ALU_MULT, 1'b1, REGSEL_NONE, 32'd3, 32'd3, 0, st, bz);
        repeat (9) @(posedge clk);
        #1;
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        valid_EX = 1'b1; regsel_EX = REGSEL_LO;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_stall", {31'd0, stall_o}, 32'd0);
        chk("midrst_mflo", hilo_rdata, 32'd0);
        valid_EX = 1'b0; regsel_EX = '0;
        issue(4'h0, 1'b0, REGSEL_HI, 0, 0, 32'h0, st, bz);
        chk("midrst_mfhi_stall", st, 0);
        issue(4'h0, 1'b0, REGSEL_LO, 0, 0, 32'h0, st, bz);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hilo_mult_unit.md
# hilo_mult_unit

Execute-stage HI/LO unit: consumes the decoded EX-stage control bundle (`alu_op`, `enhilo_EX`, `regsel_EX`) plus register operands. It runs MULT/MULTU as an iterative shift-add multiply into the HI/LO register pair and serves MFHI/MFLO reads. It stalls the pipeline only for instructions that depend on an in-flight multiply. It sits beside the ALU in EX; its read data feeds the writeback mux.

## Interface
- `XLEN`, default 32: operand width; HI and LO are each `XLEN` bits; product is `2*XLEN` bits.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `valid_EX` in 1: an instruction is present in EX this cycle.
- `alu_op` in 4: `ALU_MULT` (4'b0110, signed) or `ALU_MULTU` (4'b0111, unsigned); other values are ignored here.
- `enhilo_EX` in 1: instruction is MULT/MULTU; HI/LO will be written.
- `regsel_EX` in 2: `REGSEL_HI` (01) = MFHI, `REGSEL_LO` (10) = MFLO, 00 = none, 11 = reserved (treated as none).
- `rs_data` in XLEN: multiplicand.
- `rt_data` in XLEN: multiplier.
- `busy` out 1: multiply in progress.
- `stall_o` out 1: hold EX and earlier stages this cycle.
- `hilo_rdata` out XLEN: HI for MFHI, LO for MFLO, 0 otherwise.

## Operation
- Reset (rst=0 at an edge): state=IDLE, HI=LO=0, accumulator/counter=0; `busy`=0, `stall_o`=0, `hilo_rdata`=0.
- FSM states:
  - IDLE.
  - RUN: counter 0..XLEN-1, one multiplier bit per cycle.
  - FIX: sign correction and HI/LO write.
- IDLE -> RUN:
  - Trigger: `valid_EX & enhilo_EX` and `alu_op` ∈ {MULT, MULTU}.
  - Latch |rs| and |rt| (signed) or raw values (unsigned).
  - Latch `neg = rs[XLEN-1]^rt[XLEN-1]` for signed ops, `neg = 0` for unsigned.
  - Clear the 2*XLEN accumulator.
- RUN:
  - If the multiplier LSB is 1, add the multiplicand, shifted, into the accumulator.
  - Shift the multiplier right.
  - After counter = XLEN-1, go to FIX.
- FIX:
  - `{HI,LO} <=` `neg` ? two's complement of the accumulator : the accumulator.
  - Go to IDLE.
- Absolute value of the most negative operand (0x80000000) is 2^31 treated as unsigned; this must produce correct results.
- `enhilo_EX` with an `alu_op` other than MULT/MULTU: no start, no error.
- `hilo_rdata` is combinational from the HI/LO registers and `regsel_EX`; it always reflects committed HI/LO.

## Timing
- Accept edge T0 → `busy`=1 from T0+1 through T0+XLEN+1 (XLEN+1 cycles).
- HI/LO are updated at the end of FIX; visible in cycle T0+XLEN+2, when `busy`=0.
- `stall_o = busy & valid_EX & (enhilo_EX | regsel_EX==01 | regsel_EX==10)`; combinational.
  - Independent instructions never stall.
- A MULT arriving while busy is held by `stall_o` and not accepted.
  - It is accepted in the first cycle `busy`=0, the same cycle the prior result becomes readable.
  - Back-to-back accept is allowed.
- MFHI/MFLO while busy: stalled. In the first non-busy cycle `hilo_rdata` shows the new HI/LO.
- Reset mid-operation: the in-flight multiply is abandoned, HI=LO=0, next cycle IDLE.
- HI/LO are never partially updated.

## Structure
- Shared package `hilo_pkg`:
  - `ALU_MULT` and `ALU_MULTU` constants.
  - `REGSEL_HI` and `REGSEL_LO` constants.
  - FSM enum `hilo_state_t` {IDLE, RUN, FIX}.
- Sub-module `mult_iter_core`:
  - Shift-add datapath: operand registers, accumulator, counter.
  - Handshake: `start`/`done` pulses with `neg` handling.
- The top level holds the FSM glue, HI/LO registers, stall logic and read mux.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `busy` high for 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 (0xFFFFFFFD) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU on the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000.
- MFHI presented one cycle after accept → `stall_o`=1 for 32 cycles; on release `hilo_rdata` = new HI. An ADD (`enhilo_EX`=0, `regsel_EX`=00) during the multiply → `stall_o`=0.
- Second MULT while busy → stalled, first result committed intact, then the second runs; the final HI/LO equal the second product.
- `rst`=0 at RUN cycle 10 → next cycle `busy`=0, `stall_o`=0, HI=LO=0, MFLO reads 0.
